// File: rtl/unidad_de_control_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes,
// strobe bit positions and select codes.
package unidad_de_control_pkg;

  // Controller states (2-bit encoding visible on the state register)
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_MEM   = 2'b10,
    ST_WB    = 2'b11
  } state_t;

  // Opcodes (Instruccion[15:9]); 01..0F are ALU operations
  localparam logic [6:0] OP_NOP    = 7'h00;
  localparam logic [6:0] OP_LOAD   = 7'h10;
  localparam logic [6:0] OP_STORE  = 7'h11;
  localparam logic [6:0] OP_JUMP   = 7'h12;
  localparam logic [6:0] OP_CALL   = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h14;
  localparam logic [6:0] OP_MOVCR  = 7'h15;
  localparam logic [6:0] OP_SETS   = 7'h16;

  // Rta_Control bit positions
  localparam int CTL_MEM_WRITE = 5;
  localparam int CTL_MEM_READ  = 4;
  localparam int CTL_LOAD_S    = 3;
  localparam int CTL_SEL_S_HI  = 2;
  localparam int CTL_SEL_S_LO  = 1;
  localparam int CTL_NEG_S     = 0;

  // Rta_LoadSelect bit positions
  localparam int LS_SELECT_DR   = 10;
  localparam int LS_LOAD_DR     = 9;
  localparam int LS_SELECT_AR   = 8;
  localparam int LS_LOAD_AR     = 7;
  localparam int LS_SEL_PC_HI   = 6;
  localparam int LS_SEL_PC_LO   = 5;
  localparam int LS_LOAD_PC     = 4;
  localparam int LS_LOAD_IR     = 3;
  localparam int LS_LOAD_CR     = 2;
  localparam int LS_WRITE_SEL   = 1;
  localparam int LS_WRITE_EN    = 0;

  // PC source select codes
  localparam logic [1:0] PC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_REL    = 2'b01;
  localparam logic [1:0] PC_REG_A  = 2'b10;

  // ALU operations occupy opcodes 01..0F
  function automatic logic is_alu_op(input logic [6:0] op);
    return (op[6:4] == 3'b000) && (op[3:0] != 4'h0);
  endfunction

endpackage

// File: rtl/uc_decoder.sv
// Combinational decode of (state, instruction) into datapath strobes,
// register-file addresses, ALU function and the next controller state.
module uc_decoder
  import unidad_de_control_pkg::*;
(
  input  state_t      state_i,
  input  logic [15:0] instr_i,
  output logic [5:0]  control_o,
  output logic [10:0] load_select_o,
  output logic [2:0]  write_addr_o,
  output logic [2:0]  read_addr_a_o,
  output logic [2:0]  read_addr_b_o,
  output logic [3:0]  fun_o,
  output state_t      next_state_o
);

  logic [6:0] op;

  assign op            = instr_i[15:9];
  assign write_addr_o  = instr_i[8:6];
  assign read_addr_a_o = instr_i[5:3];
  assign read_addr_b_o = instr_i[2:0];

  // Strobes and next state; everything not explicitly raised stays 0
  always_comb begin
    control_o     = '0;
    load_select_o = '0;
    fun_o         = '0;
    next_state_o  = ST_FETCH;
    unique case (state_i)
      ST_FETCH: begin
        control_o[CTL_MEM_READ]                  = 1'b1;
        load_select_o[LS_LOAD_IR]                = 1'b1;
        load_select_o[LS_LOAD_PC]                = 1'b1;
        load_select_o[LS_SEL_PC_HI:LS_SEL_PC_LO] = PC_PLUS1;
        next_state_o                             = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_alu_op(op)) begin
          fun_o                      = op[3:0];
          load_select_o[LS_LOAD_DR]  = 1'b1;
          load_select_o[LS_SELECT_DR] = 1'b0;
          control_o[CTL_LOAD_S]      = 1'b1;
          control_o[CTL_SEL_S_HI:CTL_SEL_S_LO] = 2'b00;
          next_state_o               = ST_WB;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: begin
              load_select_o[LS_LOAD_AR]   = 1'b1;
              load_select_o[LS_SELECT_AR] = 1'b0;
              next_state_o                = ST_MEM;
            end
            OP_JUMP: begin
              load_select_o[LS_LOAD_PC]                = 1'b1;
              load_select_o[LS_SEL_PC_HI:LS_SEL_PC_LO] = PC_REG_A;
            end
            OP_CALL: begin
              // Return address (PC) goes to Rd while PC jumps to reg A
              load_select_o[LS_WRITE_EN]               = 1'b1;
              load_select_o[LS_WRITE_SEL]              = 1'b1;
              load_select_o[LS_LOAD_PC]                = 1'b1;
              load_select_o[LS_SEL_PC_HI:LS_SEL_PC_LO] = PC_REG_A;
            end
            OP_BRANCH: begin
              load_select_o[LS_LOAD_PC]                = 1'b1;
              load_select_o[LS_SEL_PC_HI:LS_SEL_PC_LO] = PC_REL;
            end
            OP_MOVCR: begin
              load_select_o[LS_LOAD_CR] = 1'b1;
            end
            OP_SETS: begin
              control_o[CTL_LOAD_S]                = 1'b1;
              control_o[CTL_SEL_S_HI:CTL_SEL_S_LO] = instr_i[1:0];
              control_o[CTL_NEG_S]                 = instr_i[2];
            end
            default: begin
              // NOP and illegal opcodes: no strobes, back to fetch
            end
          endcase
        end
      end
      ST_MEM: begin
        if (op == OP_LOAD) begin
          control_o[CTL_MEM_READ]     = 1'b1;
          load_select_o[LS_LOAD_DR]   = 1'b1;
          load_select_o[LS_SELECT_DR] = 1'b1;
          next_state_o                = ST_WB;
        end else if (op == OP_STORE) begin
          // Store data is taken from read port B
          control_o[CTL_MEM_WRITE] = 1'b1;
        end
      end
      ST_WB: begin
        load_select_o[LS_WRITE_EN]  = 1'b1;
        load_select_o[LS_WRITE_SEL] = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/unidad_de_control.sv
// Multicycle control unit: state register plus reset gating around the
// combinational decoder. Reset abandons any instruction in flight.
module unidad_de_control
  import unidad_de_control_pkg::*;
(
  input  logic        Reloj,
  input  logic        Reiniciar,
  input  logic [15:0] Instruccion,
  output logic [5:0]  Rta_Control,
  output logic [10:0] Rta_LoadSelect,
  output logic [2:0]  Rta_WriteAddress,
  output logic [2:0]  Rta_ReadAddressA,
  output logic [2:0]  Rta_ReadAddressB,
  output logic [3:0]  Rta_Fun
);

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  control_w;
  logic [10:0] load_select_w;
  logic [2:0]  write_addr_w;
  logic [2:0]  read_addr_a_w;
  logic [2:0]  read_addr_b_w;
  logic [3:0]  fun_w;

  uc_decoder u_decoder (
    .state_i       (state_q),
    .instr_i       (Instruccion),
    .control_o     (control_w),
    .load_select_o (load_select_w),
    .write_addr_o  (write_addr_w),
    .read_addr_a_o (read_addr_a_w),
    .read_addr_b_o (read_addr_b_w),
    .fun_o         (fun_w),
    .next_state_o  (state_d)
  );

  // State register; reset forces FETCH regardless of the decoded transition
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are held at zero for as long as reset is asserted
  always_comb begin
    Rta_Control      = '0;
    Rta_LoadSelect   = '0;
    Rta_WriteAddress = '0;
    Rta_ReadAddressA = '0;
    Rta_ReadAddressB = '0;
    Rta_Fun          = '0;
    if (!Reiniciar) begin
      Rta_Control      = control_w;
      Rta_LoadSelect   = load_select_w;
      Rta_WriteAddress = write_addr_w;
      Rta_ReadAddressA = read_addr_a_w;
      Rta_ReadAddressB = read_addr_b_w;
      Rta_Fun          = fun_w;
    end
  end

endmodule

// File: tb/tb_unidad_de_control.sv
// Directed bench for the control unit: walks each instruction class through
// its states and compares every output against hand-computed values.
module tb_unidad_de_control;

  logic        Reloj;
  logic        Reiniciar;
  logic [15:0] Instruccion;
  logic [5:0]  Rta_Control;
  logic [10:0] Rta_LoadSelect;
  logic [2:0]  Rta_WriteAddress;
  logic [2:0]  Rta_ReadAddressA;
  logic [2:0]  Rta_ReadAddressB;
  logic [3:0]  Rta_Fun;

  int checks   = 0;
  int failures = 0;

  unidad_de_control dut (
    .Reloj            (Reloj),
    .Reiniciar        (Reiniciar),
    .Instruccion      (Instruccion),
    .Rta_Control      (Rta_Control),
    .Rta_LoadSelect   (Rta_LoadSelect),
    .Rta_WriteAddress (Rta_WriteAddress),
    .Rta_ReadAddressA (Rta_ReadAddressA),
    .Rta_ReadAddressB (Rta_ReadAddressB),
    .Rta_Fun          (Rta_Fun)
  );

  initial Reloj = 1'b0;
  always #5 Reloj = ~Reloj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output port at once
  task automatic chk_all(input string tag, input logic [5:0] c, input logic [10:0] ls,
                         input logic [2:0] wa, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [3:0] fun);
    chk({tag, ".ctrl"}, 32'(Rta_Control), 32'(c));
    chk({tag, ".ls"},   32'(Rta_LoadSelect), 32'(ls));
    chk({tag, ".wa"},   32'(Rta_WriteAddress), 32'(wa));
    chk({tag, ".ra"},   32'(Rta_ReadAddressA), 32'(ra));
    chk({tag, ".rb"},   32'(Rta_ReadAddressB), 32'(rb));
    chk({tag, ".fun"},  32'(Rta_Fun), 32'(fun));
    $display("step %-14s ctrl=%02h ls=%03h wa=%0d ra=%0d rb=%0d fun=%0h",
             tag, Rta_Control, Rta_LoadSelect, Rta_WriteAddress,
             Rta_ReadAddressA, Rta_ReadAddressB, Rta_Fun);
  endtask

  // Advance one clock edge and settle just after it
  task automatic step();
    @(posedge Reloj);
    #1;
  endtask

  initial begin
    Reiniciar   = 1'b1;
    Instruccion = 16'h0AE5;
    step();
    step();
    chk_all("reset", 6'h00, 11'h000, 3'd0, 3'd0, 3'd0, 4'h0);

    // Release: first FETCH
    Reiniciar = 1'b0;
    #1;
    chk_all("fetch0", 6'h10, 11'h018, 3'd3, 3'd4, 3'd5, 4'h0);

    // ALU op 3
    Instruccion = 16'h060A;
    step(); chk_all("alu3.exec", 6'h08, 11'h200, 3'd0, 3'd1, 3'd2, 4'h3);
    step(); chk_all("alu3.wb",   6'h00, 11'h001, 3'd0, 3'd1, 3'd2, 4'h0);
    step(); chk_all("alu3.fetch", 6'h10, 11'h018, 3'd0, 3'd1, 3'd2, 4'h0);

    // ALU op 5 with non-zero register fields
    Instruccion = 16'h0AE5;
    step(); chk_all("alu5.exec", 6'h08, 11'h200, 3'd3, 3'd4, 3'd5, 4'h5);
    step(); chk_all("alu5.wb",   6'h00, 11'h001, 3'd3, 3'd4, 3'd5, 4'h0);
    step(); chk_all("alu5.fetch", 6'h10, 11'h018, 3'd3, 3'd4, 3'd5, 4'h0);

    // Highest ALU opcode 0F
    Instruccion = 16'h1E00;
    step(); chk_all("aluF.exec", 6'h08, 11'h200, 3'd0, 3'd0, 3'd0, 4'hF);
    step(); chk_all("aluF.wb",   6'h00, 11'h001, 3'd0, 3'd0, 3'd0, 4'h0);
    step();

    // LOAD
    Instruccion = 16'h2050;
    step(); chk_all("load.exec", 6'h00, 11'h080, 3'd1, 3'd2, 3'd0, 4'h0);
    step(); chk_all("load.mem",  6'h10, 11'h600, 3'd1, 3'd2, 3'd0, 4'h0);
    step(); chk_all("load.wb",   6'h00, 11'h001, 3'd1, 3'd2, 3'd0, 4'h0);
    step(); chk_all("load.fetch", 6'h10, 11'h018, 3'd1, 3'd2, 3'd0, 4'h0);

    // STORE
    Instruccion = 16'h2203;
    step(); chk_all("store.exec", 6'h00, 11'h080, 3'd0, 3'd0, 3'd3, 4'h0);
    step(); chk_all("store.mem",  6'h20, 11'h000, 3'd0, 3'd0, 3'd3, 4'h0);
    step(); chk_all("store.fetch", 6'h10, 11'h018, 3'd0, 3'd0, 3'd3, 4'h0);

    // JUMP
    Instruccion = 16'h2408;
    step(); chk_all("jump.exec", 6'h00, 11'h050, 3'd0, 3'd1, 3'd0, 4'h0);
    step(); chk_all("jump.fetch", 6'h10, 11'h018, 3'd0, 3'd1, 3'd0, 4'h0);

    // CALL
    Instruccion = 16'h2600;
    step(); chk_all("call.exec", 6'h00, 11'h053, 3'd0, 3'd0, 3'd0, 4'h0);
    step(); chk_all("call.fetch", 6'h10, 11'h018, 3'd0, 3'd0, 3'd0, 4'h0);

    // BRANCH
    Instruccion = 16'h2800;
    step(); chk_all("branch.exec", 6'h00, 11'h030, 3'd0, 3'd0, 3'd0, 4'h0);
    step();

    // MOVCR
    Instruccion = 16'h2A00;
    step(); chk_all("movcr.exec", 6'h00, 11'h004, 3'd0, 3'd0, 3'd0, 4'h0);
    step();

    // SETS: SelectS=10, NegS=1
    Instruccion = 16'h2C06;
    step(); chk_all("sets.exec", 6'h0D, 11'h000, 3'd0, 3'd0, 3'd6, 4'h0);
    step(); chk_all("sets.fetch", 6'h10, 11'h018, 3'd0, 3'd0, 3'd6, 4'h0);

    // Illegal opcode 17: no strobes, back to FETCH
    Instruccion = 16'h2E00;
    step(); chk_all("ill17.exec", 6'h00, 11'h000, 3'd0, 3'd0, 3'd0, 4'h0);
    step(); chk_all("ill17.fetch", 6'h10, 11'h018, 3'd0, 3'd0, 3'd0, 4'h0);

    // NOP
    Instruccion = 16'h0000;
    step(); chk_all("nop.exec", 6'h00, 11'h000, 3'd0, 3'd0, 3'd0, 4'h0);
    step(); chk_all("nop.fetch", 6'h10, 11'h018, 3'd0, 3'd0, 3'd0, 4'h0);

    // Reset at the edge that would enter WB of an ALU op
    Instruccion = 16'h060A;
    step(); chk_all("rst.exec", 6'h08, 11'h200, 3'd0, 3'd1, 3'd2, 4'h3);
    Reiniciar = 1'b1;
    #1;
    chk_all("rst.gated", 6'h00, 11'h000, 3'd0, 3'd0, 3'd0, 4'h0);
    step();
    chk_all("rst.held", 6'h00, 11'h000, 3'd0, 3'd0, 3'd0, 4'h0);
    Reiniciar = 1'b0;
    #1;
    chk_all("rst.fetch", 6'h10, 11'h018, 3'd0, 3'd1, 3'd2, 4'h0);

    // Short reset pulse between edges: outputs gated, state untouched
    step(); chk_all("pulse.exec", 6'h08, 11'h200, 3'd0, 3'd1, 3'd2, 4'h3);
    Reiniciar = 1'b1;
    #2;
    chk_all("pulse.gated", 6'h00, 11'h000, 3'd0, 3'd0, 3'd0, 4'h0);
    Reiniciar = 1'b0;
    #1;
    chk_all("pulse.after", 6'h08, 11'h200, 3'd0, 3'd1, 3'd2, 4'h3);
    step(); chk_all("pulse.wb", 6'h00, 11'h001, 3'd0, 3'd1, 3'd2, 4'h0);
    step(); chk_all("pulse.fetch", 6'h10, 11'h018, 3'd0, 3'd1, 3'd2, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
